// File: rtl/fp.sv
// Floating-point parameter word type shared by the dendrite array.
// fpType: one analog-parameter word as carried on the config chain.
package fp;

    typedef logic [7:0] fpType;

endpackage

// File: rtl/row_cfg_pkg.sv
// Row configuration chain layout and spike row-field helpers.
// Offsets are relative to NUM_PARAMS in the shadow chain.
package row_cfg_pkg;

    // Row address sits just above the parameter words, mask above that.
    localparam int ROW_ADDR_OFS = 0;
    localparam int MASK_OFS     = 1;

    // Extract the top row_w bits of an addr_w-wide spike address.
    function automatic logic [63:0] spike_row(
        input logic [63:0] addr,
        input int          addr_w,
        input int          row_w
    );
        logic [63:0] w_mask;
        w_mask = (64'd1 << row_w) - 64'd1;
        return (addr >> (addr_w - row_w)) & w_mask;
    endfunction

endpackage

// File: rtl/row_spike_if.sv
// Spike input/output bundle for one dendrite row.
// master drives spike_in_*, slave (the row) drives spike_out_*.
interface row_spike_if #(
    parameter int ADDR_W = 16
);

    logic              spike_in_valid;
    logic [ADDR_W-1:0] spike_in_address;
    logic              spike_in_on_off;
    logic              spike_out_valid;
    logic [ADDR_W-1:0] spike_out_address;
    logic              spike_out_on_off;

    modport master (
        output spike_in_valid,
        output spike_in_address,
        output spike_in_on_off,
        input  spike_out_valid,
        input  spike_out_address,
        input  spike_out_on_off
    );

    modport slave (
        input  spike_in_valid,
        input  spike_in_address,
        input  spike_in_on_off,
        output spike_out_valid,
        output spike_out_address,
        output spike_out_on_off
    );

endinterface

// File: rtl/row_spike_matcher.sv
// Row spike address matcher, registered spike forward and hit counter.
// Ports: clk/reset, configured/row_addr/mask from latch, spk bus, count.
module row_spike_matcher
    import row_cfg_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int ROW_ADDR_W = 8,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_configured,
    input  logic [ROW_ADDR_W-1:0] i_row_addr,
    input  logic [ROW_ADDR_W-1:0] i_mask,
    input  logic                  count_clear,
    row_spike_if.slave            spk,
    output logic [CNT_W-1:0]      spike_count
);

    logic [ROW_ADDR_W-1:0] w_row;
    logic                  w_hit;
    logic                  r_valid;
    logic [ADDR_W-1:0]     r_addr;
    logic                  r_on_off;
    logic [CNT_W-1:0]      r_cnt;

    assign w_row = ROW_ADDR_W'(spike_row(64'(spk.spike_in_address),
                                         ADDR_W, ROW_ADDR_W));

    // Cleared mask bits are don't-care, letting one spike hit many rows.
    assign w_hit = i_configured & spk.spike_in_valid &
                   (((w_row ^ i_row_addr) & i_mask) == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid  <= 1'b0;
            r_addr   <= '0;
            r_on_off <= 1'b0;
        end else begin
            r_valid  <= w_hit;
            r_addr   <= spk.spike_in_address;
            r_on_off <= spk.spike_in_on_off;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (count_clear) begin
            r_cnt <= '0;
        end else if (w_hit && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign spk.spike_out_valid   = r_valid;
    assign spk.spike_out_address = r_addr;
    assign spk.spike_out_on_off  = r_on_off;
    assign spike_count           = r_cnt;

endmodule

// File: rtl/row_param_chain_filter.sv
// Per-row parameter holder: shadow config chain, active latch, spike gate.
// Ports: clk/reset, cfg chain in/out, cfg_latch, params_out, spk bus, count.
module row_param_chain_filter
    import row_cfg_pkg::*;
#(
    parameter int NUM_PARAMS = 2,
    parameter int DATA_W     = $bits(fp::fpType),
    parameter int ADDR_W     = 16,
    parameter int ROW_ADDR_W = 8,
    parameter int CNT_W      = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             cfg_shift_en,
    input  logic [DATA_W-1:0]                cfg_data_in,
    output logic [DATA_W-1:0]                cfg_data_out,
    input  logic                             cfg_latch,
    output logic [NUM_PARAMS-1:0][DATA_W-1:0] params_out,
    output logic                             configured,
    row_spike_if.slave                       spk,
    input  logic                             count_clear,
    output logic [CNT_W-1:0]                 spike_count
);

    localparam int K            = NUM_PARAMS + 2;
    localparam int ROW_ADDR_IDX = NUM_PARAMS + ROW_ADDR_OFS;
    localparam int MASK_IDX     = NUM_PARAMS + MASK_OFS;

    logic [K-1:0][DATA_W-1:0]          r_shadow;
    logic [NUM_PARAMS-1:0][DATA_W-1:0] r_params;
    logic [ROW_ADDR_W-1:0]             r_row_addr;
    logic [ROW_ADDR_W-1:0]             r_mask;
    logic                              r_configured;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow <= '0;
        end else if (cfg_shift_en) begin
            r_shadow <= {r_shadow[K-2:0], cfg_data_in};
        end
    end

    // Latch samples the pre-shift shadow, so a same-cycle shift is safe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_params     <= '0;
            r_row_addr   <= '0;
            r_mask       <= '1;
            r_configured <= 1'b0;
        end else if (cfg_latch) begin
            r_params     <= r_shadow[NUM_PARAMS-1:0];
            r_row_addr   <= r_shadow[ROW_ADDR_IDX][ROW_ADDR_W-1:0];
            r_mask       <= r_shadow[MASK_IDX][ROW_ADDR_W-1:0];
            r_configured <= 1'b1;
        end
    end

    assign cfg_data_out = r_shadow[K-1];
    assign params_out   = r_params;
    assign configured   = r_configured;

    row_spike_matcher #(
        .ADDR_W     (ADDR_W),
        .ROW_ADDR_W (ROW_ADDR_W),
        .CNT_W      (CNT_W)
    ) u_match (
        .clk          (clk),
        .reset        (reset),
        .i_configured (r_configured),
        .i_row_addr   (r_row_addr),
        .i_mask       (r_mask),
        .count_clear  (count_clear),
        .spk          (spk),
        .spike_count  (spike_count)
    );

endmodule

// File: tb/tb_row_param_chain_filter.sv
// Directed bench for row_param_chain_filter (counter width 4).
// Drives config chain and spikes, checks against hand-computed values.
module tb_row_param_chain_filter;

    localparam int NP  = 2;
    localparam int DW  = 8;
    localparam int AW  = 16;
    localparam int RW  = 8;
    localparam int CW  = 4;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     cfg_shift_en;
    logic [DW-1:0]            cfg_data_in;
    logic [DW-1:0]            cfg_data_out;
    logic                     cfg_latch;
    logic [NP-1:0][DW-1:0]    params_out;
    logic                     configured;
    logic                     count_clear;
    logic [CW-1:0]            spike_count;

    int checks = 0;
    int fails  = 0;

    row_spike_if #(.ADDR_W(AW)) spk ();

    row_param_chain_filter #(
        .NUM_PARAMS (NP),
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .ROW_ADDR_W (RW),
        .CNT_W      (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_shift_en (cfg_shift_en),
        .cfg_data_in  (cfg_data_in),
        .cfg_data_out (cfg_data_out),
        .cfg_latch    (cfg_latch),
        .params_out   (params_out),
        .configured   (configured),
        .spk          (spk),
        .count_clear  (count_clear),
        .spike_count  (spike_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift(input logic [DW-1:0] d);
        cfg_shift_en = 1'b1;
        cfg_data_in  = d;
        tick();
        cfg_shift_en = 1'b0;
    endtask

    task automatic latch();
        cfg_latch = 1'b1;
        tick();
        cfg_latch = 1'b0;
    endtask

    task automatic spike(input logic [AW-1:0] a, input logic oo);
        spk.spike_in_valid   = 1'b1;
        spk.spike_in_address = a;
        spk.spike_in_on_off  = oo;
        tick();
        spk.spike_in_valid   = 1'b0;
    endtask

    initial begin
        reset                = 1'b1;
        cfg_shift_en         = 1'b0;
        cfg_data_in          = '0;
        cfg_latch            = 1'b0;
        count_clear          = 1'b0;
        spk.spike_in_valid   = 1'b0;
        spk.spike_in_address = '0;
        spk.spike_in_on_off  = 1'b0;
        tick();
        tick();
        check("rst_params", 32'(params_out), 32'h0);
        check("rst_cfgout", 32'(cfg_data_out), 32'h0);
        check("rst_conf", 32'(configured), 32'h0);
        check("rst_count", 32'(spike_count), 32'h0);
        check("rst_sv", 32'(spk.spike_out_valid), 32'h0);
        reset = 1'b0;
        tick();

        // Before any latch: dropped, not counted
        spike(16'h0000, 1'b1);
        check("pre_sv", 32'(spk.spike_out_valid), 32'h0);
        check("pre_oo", 32'(spk.spike_out_on_off), 32'h1);
        check("pre_cnt", 32'(spike_count), 32'h0);

        // Config load: mask FF, row 05, p1 22, p0 11
        shift(8'hFF);
        shift(8'h05);
        shift(8'h22);
        check("lat3_cfgout", 32'(cfg_data_out), 32'h0);
        shift(8'h11);
        check("lat4_cfgout", 32'(cfg_data_out), 32'hFF);
        check("noshift_p", 32'(params_out), 32'h0);
        latch();
        check("ld_p0", 32'(params_out[0]), 32'h11);
        check("ld_p1", 32'(params_out[1]), 32'h22);
        check("ld_conf", 32'(configured), 32'h1);

        // Exact match, back to back
        spk.spike_in_valid   = 1'b1;
        spk.spike_in_address = 16'h0537;
        spk.spike_in_on_off  = 1'b0;
        tick();
        check("ex_sv1", 32'(spk.spike_out_valid), 32'h1);
        check("ex_sa1", 32'(spk.spike_out_address), 32'h0537);
        spk.spike_in_address = 16'h0637;
        tick();
        spk.spike_in_valid   = 1'b0;
        check("ex_sv2", 32'(spk.spike_out_valid), 32'h0);
        check("ex_sa2", 32'(spk.spike_out_address), 32'h0637);
        check("ex_cnt", 32'(spike_count), 32'h1);

        // Masked broadcast: mask FE, row 04
        shift(8'hFE);
        shift(8'h04);
        shift(8'h22);
        shift(8'h11);
        latch();
        spike(16'h0401, 1'b0);
        check("bc_0401", 32'(spk.spike_out_valid), 32'h1);
        spike(16'h0501, 1'b1);
        check("bc_0501", 32'(spk.spike_out_valid), 32'h1);
        spike(16'h0601, 1'b0);
        check("bc_0601", 32'(spk.spike_out_valid), 32'h0);
        check("bc_cnt", 32'(spike_count), 32'h3);

        // Shadow stability
        shift(8'hAA);
        shift(8'hBB);
        shift(8'hCC);
        shift(8'hDD);
        check("sh_p0", 32'(params_out[0]), 32'h11);
        check("sh_p1", 32'(params_out[1]), 32'h22);
        cfg_shift_en = 1'b1;
        cfg_data_in  = 8'h77;
        cfg_latch    = 1'b1;
        tick();
        cfg_shift_en = 1'b0;
        cfg_latch    = 1'b0;
        check("sl_p0", 32'(params_out[0]), 32'hDD);
        check("sl_p1", 32'(params_out[1]), 32'hCC);
        check("sl_cfgout", 32'(cfg_data_out), 32'hBB);
        // Active row BB, mask AA: 0xBB00 hits, 0xBA00 hits (bit0 dc)
        spike(16'hBA00, 1'b0);
        check("sl_hit", 32'(spk.spike_out_valid), 32'h1);
        spike(16'hB900, 1'b0);
        check("sl_miss", 32'(spk.spike_out_valid), 32'h0);

        // Counter: clear, accept-all mask, saturate
        count_clear = 1'b1;
        tick();
        count_clear = 1'b0;
        check("clr_cnt", 32'(spike_count), 32'h0);
        shift(8'h00);
        shift(8'h00);
        shift(8'h22);
        shift(8'h11);
        latch();
        spk.spike_in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            spk.spike_in_address = 16'(i * 16'h0111);
            tick();
        end
        check("sat_sv", 32'(spk.spike_out_valid), 32'h1);
        check("sat_cnt", 32'(spike_count), 32'hF);
        count_clear = 1'b1;
        tick();
        count_clear = 1'b0;
        spk.spike_in_valid = 1'b0;
        check("clrhit_cnt", 32'(spike_count), 32'h0);
        check("clrhit_sv", 32'(spk.spike_out_valid), 32'h1);
        spike(16'h1234, 1'b0);
        check("post_cnt", 32'(spike_count), 32'h1);

        // Reset mid-shift
        shift(8'h5A);
        cfg_shift_en = 1'b1;
        cfg_data_in  = 8'hA5;
        spk.spike_in_valid = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("mr_params", 32'(params_out), 32'h0);
        check("mr_cfgout", 32'(cfg_data_out), 32'h0);
        check("mr_conf", 32'(configured), 32'h0);
        check("mr_cnt", 32'(spike_count), 32'h0);
        check("mr_sv", 32'(spk.spike_out_valid), 32'h0);
        check("mr_sa", 32'(spk.spike_out_address), 32'h0);
        tick();
        cfg_shift_en = 1'b0;
        reset = 1'b0;
        spk.spike_in_address = 16'h0000;
        tick();
        check("mr_drop_sv", 32'(spk.spike_out_valid), 32'h0);
        check("mr_drop_cnt", 32'(spike_count), 32'h0);
        spk.spike_in_valid = 1'b0;

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/row_param_chain_filter.md
Name: row_param_chain_filter

Overview:
- Per-row configuration and spike-gating block for the dendrite array: a generalised row-global parameter holder.
- A config word chain, K = NUM_PARAMS+2 stages, carries NUM_PARAMS analog-parameter words plus a row address and a row match mask, and daisy-chains to the next row.
- Shadow/active double buffering keeps the parameter outputs stable while the chain shifts.
- Incoming spikes are address-matched against the active row address under the mask and forwarded with one registered cycle; accepted spikes are counted.

Parameters:
- NUM_PARAMS, 2, number of fp::fpType parameter words per row (E_l, E_rev, ...).
- DATA_W, 8, config word width; equals $bits(fp::fpType).
- ADDR_W, 16, spike address width.
- ROW_ADDR_W, 8, row field width, taken from spike address bits [ADDR_W-1 -: ROW_ADDR_W]; must be <= DATA_W.
- CNT_W, 16, width of the accepted-spike counter.

Ports:
- clk  in  1  single clock for config and spike paths.
- reset  in  1  asynchronous, active-high.
- cfg_shift_en  in  1  shift chain one stage this cycle.
- cfg_data_in  in  DATA_W  chain input from the previous row.
- cfg_data_out  out  DATA_W  chain output to the next row; this is the last stage register.
- cfg_latch  in  1  copy shadow stages to active registers.
- params_out  out  NUM_PARAMS x DATA_W  active parameter words; element i = param i.
- configured  out  1  set by the first cfg_latch after reset.
- spike_in_valid / spike_in_address / spike_in_on_off  in  1 / ADDR_W / 1.
- spike_out_valid / spike_out_address / spike_out_on_off  out  1 / ADDR_W / 1.
- count_clear  in  1  synchronous clear of spike_count.
- spike_count  out  CNT_W  saturating count of accepted spikes.

Behaviour:
- Reset, asynchronous:
  - All shadow stages, params_out, cfg_data_out, row address, spike_out_* and spike_count go to 0.
  - Active mask goes to all ones.
  - configured goes to 0.
- Chain:
  - Shadow stages S[0..K-1]; S[0] is fed from cfg_data_in; cfg_data_out = S[K-1].
  - On cfg_shift_en: S[0] <= cfg_data_in and S[j] <= S[j-1].
  - The first word shifted is the mask and ends in S[K-1]; the row address ends in S[K-2].
  - The last NUM_PARAMS words end in S[NUM_PARAMS-1..0].
  - Input-to-output latency is K shift cycles.
- Latch:
  - On cfg_latch: params_out[i] <= S[i] for i < NUM_PARAMS; row_addr <= S[NUM_PARAMS][ROW_ADDR_W-1:0]; mask <= S[NUM_PARAMS+1][ROW_ADDR_W-1:0]; configured <= 1.
  - cfg_shift_en and cfg_latch in the same cycle: the latch captures the pre-shift shadow values and the shift still happens.
  - Shifting without a latch never changes params_out.
- Spike match, combinational:
  - hit = configured & spike_in_valid & ((spike_row ^ row_addr) & mask) == 0.
  - Mask bit 0 means "don't care", which allows multi-row broadcast.
- Spike output, registered with 1-cycle latency:
  - Every cycle, spike_out_valid <= hit.
  - spike_out_address and spike_out_on_off are registered from the inputs every cycle, unqualified.
  - A back-to-back spike stream is sustained at one per cycle. There is no backpressure.
- Counter:
  - count_clear has priority and sets spike_count <= 0, even when hit is set in the same cycle.
  - Otherwise hit increments spike_count, saturating at 2^CNT_W-1.
- Reset mid-shift: partial shadow contents are lost and configured drops. Software reshifts the full K words and latches.
- Spikes arriving before the first latch are dropped and not counted.

Decomposition:
- Package fp: fpType.
- New package row_cfg_pkg: chain-position localparam offsets (ROW_ADDR_IDX = NUM_PARAMS, MASK_IDX = NUM_PARAMS+1) and the spike row-field extraction function.
- One sub-module, row_spike_matcher: match logic, output register and saturating counter. Chain and latch logic stay in the top.

Test Plan:
- Config load, defaults:
  - Stimulus: shift 0xFF, 0x05, 0x22, 0x11, then pulse cfg_latch.
  - Required: params_out[0] = 0x11, params_out[1] = 0x22, configured = 1.
  - Required: cfg_data_out shows 0xFF after the 4th shift.
- Exact match:
  - Stimulus: spike 0x0537, then 0x0637.
  - Required: spike_out_valid = 1 with address 0x0537 one cycle later, then 0 for 0x0637; spike_count = 1.
- Masked broadcast:
  - Stimulus: latch mask 0xFE, row 0x04.
  - Required: spikes 0x0401 and 0x0501 are accepted; 0x0601 is rejected.
- Shadow stability:
  - Stimulus: shift 4 new words without a latch.
  - Required: params_out is unchanged.
  - Stimulus: shift and latch in the same cycle.
  - Required: the pre-shift values are latched.
- Pre-config and reset:
  - Stimulus: spike 0x0000 before any latch.
  - Required: no output, count 0.
  - Stimulus: assert reset mid-shift.
  - Required: all outputs 0, configured = 0.
- Counter:
  - Stimulus: CNT_W = 4 with 20 accepted spikes.
  - Required: count stays at 15.
  - Stimulus: count_clear together with a hit.
  - Required: count is 0.
